// File: rtl/two_level_pkg.sv
// Shared definitions for the two-level deframer: widths, default sync word,
// hunt/payload state encoding and the sample-to-bit slicer.
package two_level_pkg;

  localparam int TL_SAMPLE_W    = 16;
  localparam int TL_SYNC_W      = 16;
  localparam int TL_WORD_W      = 16;
  localparam int TL_FRAME_WORDS = 8;
  localparam logic [TL_SYNC_W-1:0] TL_SYNC_WORD = 16'hA5F0;

  typedef enum logic [0:0] {
    ST_HUNT    = 1'b0,
    ST_PAYLOAD = 1'b1
  } deframer_state_e;

  // A sample at or above zero is a 1, a negative sample is a 0.
  function automatic logic slice_bit(input logic sign_bit);
    return ~sign_bit;
  endfunction

endpackage

// File: rtl/two_level_deframer_word_out_reg.sv
// One-entry valid/ready holding register. A load is accepted when the entry
// is empty or is being drained in the same cycle; otherwise the new data is
// dropped and a sticky overflow flag is raised.
module word_out_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  output logic         overflow_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;
  logic         accept_s;

  // Decide between refill, drain or drop for this cycle.
  always_comb begin
    accept_s = load_i && (!valid_q || out_ready_i);
    data_d   = data_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    if (accept_s) begin
      data_d  = load_data_i;
      valid_d = 1'b1;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (load_i && !accept_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Holding register state; reset discards any pending entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/two_level_deframer.sv
// Two-level deframer: slices rounded samples to bits, hunts for the sync
// word, then packs FRAME_WORDS payload words MSB-first and hands them out
// through a one-entry valid/ready register.
// Optional build macro DEFRAMER_ERASURE_EN adds per-word erasure tagging
// (a sample of exactly zero) with out_erasure_o and erasure_count_o ports.
module two_level_deframer
  import two_level_pkg::*;
#(
  parameter int SAMPLE_W    = TL_SAMPLE_W,
  parameter int SYNC_W      = TL_SYNC_W,
  parameter int WORD_W      = TL_WORD_W,
  parameter int FRAME_WORDS = TL_FRAME_WORDS,
  parameter logic [SYNC_W-1:0] SYNC_WORD = TL_SYNC_WORD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic [SAMPLE_W-1:0] in_sample_i,
  input  logic                in_valid_i,
  output logic [WORD_W-1:0]   out_word_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                locked_o,
  output logic                frame_done_o,
`ifdef DEFRAMER_ERASURE_EN
  output logic                out_erasure_o,
  output logic [3:0]          erasure_count_o,
`endif
  output logic                overflow_o
);

  localparam int BIT_CNT_W  = $clog2(WORD_W);
  localparam int WORD_CNT_W = $clog2(FRAME_WORDS);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(WORD_W - 1);
  localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(FRAME_WORDS - 1);

`ifdef DEFRAMER_ERASURE_EN
  localparam int OUT_W = WORD_W + 1;
`else
  localparam int OUT_W = WORD_W;
`endif

  deframer_state_e         state_q, state_d;
  logic [SYNC_W-1:0]       sync_q, sync_d;
  logic [WORD_W-1:0]       acc_q, acc_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic                    frame_done_q, frame_done_d;

  logic                    sample_v_s;
  logic                    bit_s;
  logic [SYNC_W-1:0]       sync_shift_s;
  logic [WORD_W-1:0]       acc_shift_s;
  logic                    word_done_s;
  logic [OUT_W-1:0]        load_data_s;
  logic [OUT_W-1:0]        held_data_s;

`ifdef DEFRAMER_ERASURE_EN
  logic                    word_erase_q, word_erase_d;
  logic [3:0]              erasure_count_q, erasure_count_d;
  logic                    word_erase_full_s;
`endif

  assign sample_v_s   = en_i && in_valid_i;
  assign bit_s        = slice_bit(in_sample_i[SAMPLE_W-1]);
  assign sync_shift_s = {sync_q[SYNC_W-2:0], bit_s};
  assign acc_shift_s  = {acc_q[WORD_W-2:0], bit_s};
`ifdef DEFRAMER_ERASURE_EN
  assign word_erase_full_s = word_erase_q | (in_sample_i == '0);
`endif

  // Hunt/payload sequencing, bit and word counting.
  always_comb begin
    state_d      = state_q;
    sync_d       = sync_q;
    acc_d        = acc_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    frame_done_d = 1'b0;
    word_done_s  = 1'b0;
`ifdef DEFRAMER_ERASURE_EN
    word_erase_d    = word_erase_q;
    erasure_count_d = erasure_count_q;
    load_data_s     = {word_erase_full_s, acc_shift_s};
`else
    load_data_s     = acc_shift_s;
`endif
    case (state_q)
      ST_HUNT: begin
        if (sample_v_s) begin
          sync_d = sync_shift_s;
          if (sync_shift_s == SYNC_WORD) begin
            state_d    = ST_PAYLOAD;
            acc_d      = '0;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
`ifdef DEFRAMER_ERASURE_EN
            word_erase_d    = 1'b0;
            erasure_count_d = 4'd0;
`endif
          end else begin
            state_d = ST_HUNT;
          end
        end else begin
          sync_d = sync_q;
        end
      end
      ST_PAYLOAD: begin
        if (sample_v_s) begin
          if (bit_cnt_q == LAST_BIT) begin
            word_done_s = 1'b1;
            acc_d       = '0;
            bit_cnt_d   = '0;
`ifdef DEFRAMER_ERASURE_EN
            word_erase_d = 1'b0;
            if (word_erase_full_s && (erasure_count_q != 4'hF)) begin
              erasure_count_d = erasure_count_q + 4'd1;
            end else begin
              erasure_count_d = erasure_count_q;
            end
`endif
            if (word_cnt_q == LAST_WORD) begin
              frame_done_d = 1'b1;
              state_d      = ST_HUNT;
              sync_d       = '0;
              word_cnt_d   = '0;
            end else begin
              word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
            end
          end else begin
            acc_d     = acc_shift_s;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
`ifdef DEFRAMER_ERASURE_EN
            word_erase_d = word_erase_full_s;
`endif
          end
        end else begin
          acc_d = acc_q;
        end
      end
      default: begin
        state_d    = ST_HUNT;
        sync_d     = '0;
        bit_cnt_d  = '0;
        word_cnt_d = '0;
      end
    endcase
  end

  // Framing state; en low freezes everything, rst dominates en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HUNT;
      sync_q     <= '0;
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else if (en_i) begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      acc_q      <= acc_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
    end else begin
      state_q    <= state_q;
      sync_q     <= sync_q;
      acc_q      <= acc_q;
      bit_cnt_q  <= bit_cnt_q;
      word_cnt_q <= word_cnt_q;
    end
  end

  // frame_done is a pulse, so it is never held across an en-low cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
    end
  end

`ifdef DEFRAMER_ERASURE_EN
  // Per-word erasure tracking and per-frame saturating erased-word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_erase_q    <= 1'b0;
      erasure_count_q <= 4'd0;
    end else if (en_i) begin
      word_erase_q    <= word_erase_d;
      erasure_count_q <= erasure_count_d;
    end else begin
      word_erase_q    <= word_erase_q;
      erasure_count_q <= erasure_count_q;
    end
  end
`endif

  word_out_reg #(
    .W (OUT_W)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (word_done_s),
    .load_data_i (load_data_s),
    .out_ready_i (out_ready_i),
    .out_data_o  (held_data_s),
    .out_valid_o (out_valid_o),
    .overflow_o  (overflow_o)
  );

  assign out_word_o   = held_data_s[WORD_W-1:0];
  assign locked_o     = (state_q == ST_PAYLOAD);
  assign frame_done_o = frame_done_q;
`ifdef DEFRAMER_ERASURE_EN
  assign out_erasure_o   = held_data_s[WORD_W];
  assign erasure_count_o = erasure_count_q;
`endif

endmodule

// File: tb/tb_two_level_deframer.sv
// Scoreboard bench for two_level_deframer: stimulus pushes expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_two_level_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic [15:0] in_sample_i;
  logic        in_valid_i;
  logic [15:0] out_word_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        locked_o;
  logic        frame_done_o;
  logic        overflow_o;
`ifdef DEFRAMER_ERASURE_EN
  logic        out_erasure_o;
  logic [3:0]  erasure_count_o;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [16:0] exp_q[$];
  int          ready_mode = 0;  // 0 ready high, 1 ready low, 2 ready from last bit of word 2
  bit          push_en = 1'b1;
  int          erase_word = -1;
  logic [15:0] sync_pat = 16'hA5F0;
  logic [31:0] false_pat = 32'hA5F1_0000;

  always #10 clk = ~clk;

  two_level_deframer dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .in_sample_i  (in_sample_i),
    .in_valid_i   (in_valid_i),
    .out_word_o   (out_word_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .locked_o     (locked_o),
    .frame_done_o (frame_done_o),
`ifdef DEFRAMER_ERASURE_EN
    .out_erasure_o   (out_erasure_o),
    .erasure_count_o (erasure_count_o),
`endif
    .overflow_o   (overflow_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted output word against the scoreboard.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got %0h expected none", out_word_o);
      end else begin
        e = exp_q.pop_front();
        check("out_word", 32'(out_word_o), 32'(e[15:0]));
`ifdef DEFRAMER_ERASURE_EN
        check("out_erasure", 32'(out_erasure_o), 32'(e[16]));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_sample(input logic [15:0] s);
    en_i        = 1'b1;
    in_valid_i  = 1'b1;
    in_sample_i = s;
    @(posedge clk);
    #1;
    in_valid_i  = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    send_sample(b ? 16'h0001 : 16'hFFFF);
  endtask

  // One non-consuming cycle: either a plain gap or en low with junk valid data.
  task automatic idle_cycle(input logic en_val);
    en_i        = en_val;
    in_valid_i  = ~en_val;
    in_sample_i = 16'($urandom);
    @(posedge clk);
    #1;
    en_i        = 1'b1;
    in_valid_i  = 1'b0;
  endtask

  task automatic send_sync();
    for (int i = 15; i >= 0; i--) begin
      if (i == 0) check("locked_before_sync", 32'(locked_o), 32'd0);
      send_bit(sync_pat[i]);
    end
    check("locked_after_sync", 32'(locked_o), 32'd1);
  endtask

  task automatic send_frame(input int nwords, input bit gaps);
    logic [15:0] wd;
    logic [15:0] smp;
    for (int w = 0; w < nwords; w++) begin
      wd = 16'(w + 1);
      for (int i = 15; i >= 0; i--) begin
        if (gaps && (i % 5 == 0)) begin
          idle_cycle(1'b1);
          idle_cycle(1'b0);
        end
        case (ready_mode)
          0:       out_ready_i = 1'b1;
          1:       out_ready_i = 1'b0;
          default: out_ready_i = (w > 1) || (w == 1 && i == 0);
        endcase
        if (i == 0 && push_en && (ready_mode != 1 || w == 0))
          exp_q.push_back({(erase_word == w), wd});
        smp = wd[i] ? 16'h0001 : 16'hFFFF;
        if (erase_word == w && i == 0) smp = 16'h0000;
        send_sample(smp);
      end
      if (ready_mode == 1) begin
        check("held_word", 32'(out_word_o), 32'h0001);
        if (push_en) check("overflow_bp", 32'(overflow_o), (w >= 1) ? 32'd1 : 32'd0);
      end else begin
        check("word_latency", 32'(out_word_o), 32'(wd));
        check("valid_latency", 32'(out_valid_o), 32'd1);
        if (ready_mode == 2) check("overflow_sim", 32'(overflow_o), 32'd0);
      end
      if (w == 7) begin
        check("frame_done", 32'(frame_done_o), 32'd1);
        check("unlock", 32'(locked_o), 32'd0);
`ifdef DEFRAMER_ERASURE_EN
        check("erasure_count", 32'(erasure_count_o), (erase_word >= 0) ? 32'd1 : 32'd0);
`endif
      end else begin
        check("frame_done_low", 32'(frame_done_o), 32'd0);
        check("locked_payload", 32'(locked_o), 32'd1);
      end
    end
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle_cycle(1'b1);
    idle_cycle(1'b1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    bit saw_lock;
    bit saw_valid;
    rst         = 1'b1;
    en_i        = 1'b1;
    in_valid_i  = 1'b0;
    in_sample_i = 16'h0000;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_word", 32'(out_word_o), 32'd0);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_locked", 32'(locked_o), 32'd0);
    check("rst_frame_done", 32'(frame_done_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);

    // Normal frame with valid gaps and en-low cycles.
    ready_mode = 0;
    send_sync();
    send_frame(8, 1'b1);
    idle_cycle(1'b1);
    check("frame_done_pulse", 32'(frame_done_o), 32'd0);
    check("no_overflow", 32'(overflow_o), 32'd0);
    drain();

    // False sync: no window of these 32 bits equals the sync word.
    saw_lock  = 1'b0;
    saw_valid = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      send_bit(false_pat[i]);
      saw_lock  = saw_lock | locked_o;
      saw_valid = saw_valid | out_valid_o;
    end
    check("false_sync_locked", 32'(saw_lock), 32'd0);
    check("false_sync_valid", 32'(saw_valid), 32'd0);

    // Drain and refill in the same cycle.
    ready_mode = 2;
    send_sync();
    send_frame(8, 1'b0);
    ready_mode = 0;
    drain();
    check("sim_overflow_end", 32'(overflow_o), 32'd0);

    // Full backpressure: word 1 held, later words dropped.
    ready_mode = 1;
    send_sync();
    send_frame(8, 1'b0);
    check("bp_valid", 32'(out_valid_o), 32'd1);
    ready_mode = 0;
    drain();
    check("bp_overflow_sticky", 32'(overflow_o), 32'd1);

    // Reset after 4 words and 5 bits with a pending word.
    ready_mode = 1;
    push_en    = 1'b0;
    send_sync();
    send_frame(4, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_word", 32'(out_word_o), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_locked", 32'(locked_o), 32'd0);
    check("mid_rst_overflow", 32'(overflow_o), 32'd0);
    check("mid_rst_frame_done", 32'(frame_done_o), 32'd0);
    rst        = 1'b0;
    push_en    = 1'b1;
    ready_mode = 0;
    out_ready_i = 1'b1;
    send_sync();
    send_frame(8, 1'b0);
    drain();

    // Zero sample inside word 3.
    erase_word = 2;
    send_sync();
    send_frame(8, 1'b0);
    erase_word = -1;
    drain();
    check("final_overflow", 32'(overflow_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
